pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_lock_reset_seq.sv | 119 +++++++++++
 tb/tb_pll_lock_reset_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a qualified lock,
// then releases the downstream reset; re-runs on lock loss or software request.
module pll_lock_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 96000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TMR_W          = 20,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sw_reset_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q;
    state_e           state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             sync1_q;
    logic             lk_s;
    logic             tmo_inc;
    logic             loss_inc;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_s    <= sync1_q;
        end
    end

    // Next-state logic; software request overrides every other transition
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + TMR_W'(1);
        tmo_inc  = 1'b0;
        loss_inc = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (tmr_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = ST_STABLE;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ST_PLL_RST;
                    tmo_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (tmr_q == STB_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tmr_d = tmr_q;
                if (!lk_s) begin
                    state_d  = ST_PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (sw_reset_req) begin
            state_d  = ST_PLL_RST;
            tmo_inc  = 1'b0;
            loss_inc = 1'b0;
        end
        if (sw_reset_req || (state_d != state_q)) tmr_d = '0;
    end

    // State, timer, registered outputs and saturating counters
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_PLL_RST;
            tmr_q         <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pll_rst   <= (state_d == ST_PLL_RST);
            sys_rst_n <= (state_d == ST_RUN);
            ready     <= (state_d == ST_RUN);
            if (tmo_inc && (timeout_cnt != CNT_MAX)) timeout_cnt <= timeout_cnt + CNT_W'(1);
            if (loss_inc && (lock_loss_cnt != CNT_MAX)) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: cycle model feeds an expectation queue, plus
// directed latency/duration checks. Two DUTs share stimulus (8-bit and 2-bit counters).
module tb_pll_lock_reset_seq;

    localparam int LOCK_TO = 100;
    localparam int RST_CY  = 16;
    localparam int STB_CY  = 1024;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;

    logic       a_pll_rst, a_sys_rst_n, a_ready;
    logic [1:0] a_state;
    logic [7:0] a_lock_loss_cnt, a_timeout_cnt;
    logic       b_pll_rst, b_sys_rst_n, b_ready;
    logic [1:0] b_state;
    logic [1:0] b_lock_loss_cnt, b_timeout_cnt;

    int total = 0;
    int bad = 0;

    typedef struct { int st; int tmr; bit s1; bit s2; int tcnt; int lcnt; } mdl_t;
    typedef struct { int pll_rst; int sys_rst_n; int ready; int st; int lcnt; int tcnt; } exp_t;

    mdl_t ma, mb;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 refclk = ~refclk;

    pll_lock_reset_seq #(.PLL_RST_CYCLES(RST_CY), .LOCK_TIMEOUT(LOCK_TO), .STABLE_CYCLES(STB_CY),
                         .TMR_W(20), .CNT_W(8)) u_dut_a (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
        .pll_rst(a_pll_rst), .sys_rst_n(a_sys_rst_n), .ready(a_ready), .state(a_state),
        .lock_loss_cnt(a_lock_loss_cnt), .timeout_cnt(a_timeout_cnt));

    pll_lock_reset_seq #(.PLL_RST_CYCLES(RST_CY), .LOCK_TIMEOUT(LOCK_TO), .STABLE_CYCLES(STB_CY),
                         .TMR_W(20), .CNT_W(2)) u_dut_b (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
        .pll_rst(b_pll_rst), .sys_rst_n(b_sys_rst_n), .ready(b_ready), .state(b_state),
        .lock_loss_cnt(b_lock_loss_cnt), .timeout_cnt(b_timeout_cnt));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.tmr = 0; m.s1 = 1'b0; m.s2 = 1'b0; m.tcnt = 0; m.lcnt = 0;
        return m;
    endfunction

    // One refclk edge of the reference behaviour; lock decisions use the old s2
    function automatic mdl_t mdl_next(mdl_t m, bit lk, bit sw, int cmax);
        mdl_t n = m;
        n.s1 = lk;
        n.s2 = m.s1;
        n.tmr = m.tmr + 1;
        if (sw) begin
            n.st = 0; n.tmr = 0;
        end else if (m.st == 0) begin
            if (m.tmr == RST_CY - 1) begin n.st = 1; n.tmr = 0; end
        end else if (m.st == 1) begin
            if (m.s2) begin
                n.st = 2; n.tmr = 0;
            end else if (m.tmr == LOCK_TO - 1) begin
                n.st = 0; n.tmr = 0;
                if (n.tcnt < cmax) n.tcnt = n.tcnt + 1;
            end
        end else if (m.st == 2) begin
            if (!m.s2) begin
                n.st = 1; n.tmr = 0;
            end else if (m.tmr == STB_CY - 1) begin
                n.st = 3; n.tmr = 0;
            end
        end else begin
            if (!m.s2) begin
                n.st = 0; n.tmr = 0;
                if (n.lcnt < cmax) n.lcnt = n.lcnt + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t mdl_out(mdl_t m);
        exp_t e;
        e.pll_rst   = (m.st == 0) ? 1 : 0;
        e.sys_rst_n = (m.st == 3) ? 1 : 0;
        e.ready     = (m.st == 3) ? 1 : 0;
        e.st        = m.st;
        e.lcnt      = m.lcnt;
        e.tcnt      = m.tcnt;
        return e;
    endfunction

    // Advance one clock: predict, wait to the falling edge, compare both DUTs
    task automatic step();
        exp_t e;
        if (rst) begin
            ma = mdl_next(ma, pll_locked, sw_reset_req, 255);
            mb = mdl_next(mb, pll_locked, sw_reset_req, 3);
        end else begin
            ma = mdl_reset();
            mb = mdl_reset();
        end
        q_a.push_back(mdl_out(ma));
        q_b.push_back(mdl_out(mb));
        @(negedge refclk);
        e = q_a.pop_front();
        chk("a_pll_rst", 32'(a_pll_rst), e.pll_rst);
        chk("a_sys_rst_n", 32'(a_sys_rst_n), e.sys_rst_n);
        chk("a_ready", 32'(a_ready), e.ready);
        chk("a_state", 32'(a_state), e.st);
        chk("a_lock_loss_cnt", 32'(a_lock_loss_cnt), e.lcnt);
        chk("a_timeout_cnt", 32'(a_timeout_cnt), e.tcnt);
        e = q_b.pop_front();
        chk("b_pll_rst", 32'(b_pll_rst), e.pll_rst);
        chk("b_state", 32'(b_state), e.st);
        chk("b_lock_loss_cnt", 32'(b_lock_loss_cnt), e.lcnt);
        chk("b_timeout_cnt", 32'(b_timeout_cnt), e.tcnt);
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int n = 0;
        while ((int'(a_state) != target) && (n < bound)) begin
            step();
            n++;
        end
        chk(tag, 32'(a_state), target);
    endtask

    task automatic sw_pulse();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
    endtask

    initial begin
        int n;
        int expect_t;
        logic was_low;
        ma = mdl_reset();
        mb = mdl_reset();

        // Reset held low for 5 cycles
        repeat (5) step();
        chk("rst_pll_rst", 32'(a_pll_rst), 1);
        chk("rst_sys_rst_n", 32'(a_sys_rst_n), 0);
        chk("rst_state", 32'(a_state), 0);

        // Release: pll_rst held for exactly 16 cycles
        rst = 1'b1;
        n = 0;
        while (a_pll_rst && n < 100) begin n++; step(); end
        chk("pll_rst_len", n, RST_CY);
        chk("wait_lock_entry", 32'(a_state), 1);

        // Lock arrives inside the (shortened) timeout window
        repeat (60) step();
        pll_locked = 1'b1;
        n = 0;
        while (a_state != 2'd2 && n < 10) begin step(); n++; end
        chk("lock_to_stable_edges", n, 3);
        n = 0;
        while (!a_ready && n < 2000) begin step(); n++; end
        chk("stable_qual_len", n, STB_CY);
        chk("sys_rst_n_run", 32'(a_sys_rst_n), 1);
        chk("init_lock_loss", 32'(a_lock_loss_cnt), 0);
        chk("init_timeout", 32'(a_timeout_cnt), 0);

        // Lock loss in RUN
        repeat (5) step();
        pll_locked = 1'b0;
        n = 0;
        while (a_sys_rst_n && n < 10) begin step(); n++; end
        chk("loss_to_sysrst_edges", n, 3);
        chk("loss_pll_rst", 32'(a_pll_rst), 1);
        chk("loss_cnt", 32'(a_lock_loss_cnt), 1);
        pll_locked = 1'b1;
        run_until(3, 2000, "rerun_after_loss");

        // Software request in RUN, then again after 10 cycles of PLL reset
        repeat (3) step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        n = 0;
        while (a_pll_rst && n < 100) begin
            n++;
            if (n == 10) sw_reset_req = 1'b1;
            step();
            sw_reset_req = 1'b0;
        end
        chk("sw_pll_rst_len", n, 26);
        chk("sw_loss_cnt", 32'(a_lock_loss_cnt), 1);
        chk("sw_timeout_cnt", 32'(a_timeout_cnt), 0);
        run_until(3, 2000, "rerun_after_sw");

        // Lock glitch at STABLE timer 500
        sw_pulse();
        run_until(2, 100, "glitch_stable_entry");
        repeat (500) step();
        was_low = 1'b1;
        pll_locked = 1'b0;
        repeat (3) begin step(); if (a_sys_rst_n) was_low = 1'b0; end
        chk("glitch_to_wait", 32'(a_state), 1);
        pll_locked = 1'b1;
        run_until(2, 10, "glitch_restable");
        n = 0;
        while (!a_ready && n < 2000) begin
            if (a_sys_rst_n) was_low = 1'b0;
            step();
            n++;
        end
        chk("glitch_requal_len", n, STB_CY);
        chk("glitch_sysrst_held", 32'(was_low), 1);
        chk("glitch_loss_cnt", 32'(a_lock_loss_cnt), 1);

        // Lock never returns: timeout retries every 116 cycles
        pll_locked = 1'b0;
        run_until(0, 10, "retry_start");
        chk("retry_loss_cnt", 32'(a_lock_loss_cnt), 2);
        for (int k = 1; k <= 6; k++) begin
            n = 0;
            while (a_pll_rst && n < 300) begin step(); n++; end
            while (!a_pll_rst && n < 300) begin step(); n++; end
            chk("retry_period", n, RST_CY + LOCK_TO);
            chk("retry_timeout_cnt", 32'(a_timeout_cnt), k);
            expect_t = (k > 3) ? 3 : k;
            chk("retry_timeout_sat", 32'(b_timeout_cnt), expect_t);
        end

        // Asynchronous reset between edges during STABLE
        pll_locked = 1'b1;
        run_until(2, 300, "areset_stable_entry");
        repeat (50) step();
        #2;
        rst = 1'b0;
        #1;
        chk("areset_pll_rst", 32'(a_pll_rst), 1);
        chk("areset_sys_rst_n", 32'(a_sys_rst_n), 0);
        chk("areset_ready", 32'(a_ready), 0);
        chk("areset_state", 32'(a_state), 0);
        chk("areset_loss_cnt", 32'(a_lock_loss_cnt), 0);
        chk("areset_timeout_cnt", 32'(a_timeout_cnt), 0);
        chk("areset_b_timeout_cnt", 32'(b_timeout_cnt), 0);
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (3) step();
        rst = 1'b1;
        run_until(3, 2000, "areset_rerun");
        chk("final_loss_cnt", 32'(a_lock_loss_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
